// File: rtl/branch_cond_unit.sv
// Holds the NZCV flags and resolves CBZ/CBNZ/B.cond with a same-cycle flag bypass; counts taken branches.
// One-cycle latency to the registered resolved/taken pair; stall freezes all state and leaves br_valid unconsumed.
module branch_cond_unit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             flag_we,
    input  logic             alu_neg,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_ovf,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic [WIDTH-1:0] br_reg,
    output logic [3:0]       flags_q,
    output logic             br_resolved,
    output logic             br_taken,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [2:0] BR_B    = 3'b000;
    localparam logic [2:0] BR_CBZ  = 3'b001;
    localparam logic [2:0] BR_CBNZ = 3'b010;
    localparam logic [2:0] BR_EQ   = 3'b011;
    localparam logic [2:0] BR_NE   = 3'b100;
    localparam logic [2:0] BR_LT   = 3'b101;
    localparam logic [2:0] BR_GE   = 3'b110;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0] aluFlags;
    logic [3:0] effFlags;
    logic       opZero;
    logic       condMet;
    logic       takeNow;

    assign aluFlags = {alu_neg, alu_zero, alu_carry, alu_ovf};
    // A flag-setter in EX feeds a dependent B.cond in the same cycle.
    assign effFlags = flag_we ? aluFlags : flags_q;
    assign opZero   = (br_reg == '0);

    always_comb begin
        condMet = 1'b0;
        case (br_type)
            BR_B:    condMet = 1'b1;
            BR_CBZ:  condMet = opZero;
            BR_CBNZ: condMet = ~opZero;
            BR_EQ:   condMet = effFlags[2];
            BR_NE:   condMet = ~effFlags[2];
            BR_LT:   condMet = effFlags[3] != effFlags[0];
            BR_GE:   condMet = effFlags[3] == effFlags[0];
            default: condMet = ~effFlags[1];
        endcase
    end

    assign takeNow = br_valid & ~flush & condMet;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q     <= 4'b0000;
            br_resolved <= 1'b0;
            br_taken    <= 1'b0;
            taken_cnt   <= '0;
        end else if (!stall) begin
            if (flag_we) begin
                flags_q <= aluFlags;
            end
            br_resolved <= br_valid & ~flush;
            br_taken    <= takeNow;
            if (takeNow && taken_cnt != CNT_MAX) begin
                taken_cnt <= taken_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed vectors with hand-computed expectations, checked by a queue-based scoreboard monitor.
module tb_branch_cond_unit;

    typedef struct {
        int          idx;
        logic [3:0]  flags;
        logic        res;
        logic        taken;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        flag_we = 1'b0;
    logic [3:0]  nzcv = 4'b0000;
    logic        br_valid = 1'b0;
    logic [2:0]  br_type = 3'b000;
    logic [63:0] br_reg = 64'h0;
    logic [3:0]  flags_q;
    logic        br_resolved;
    logic        br_taken;
    logic [31:0] taken_cnt;

    logic        smValid = 1'b0;
    logic [3:0]  smFlags;
    logic        smResolved;
    logic        smTaken;
    logic [3:0]  smCnt;

    int checks = 0;
    int failures = 0;
    int vecIdx = 0;
    exp_t expQ[$];

    always #5 clk = ~clk;

    branch_cond_unit #(.WIDTH(64), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flag_we(flag_we),
        .alu_neg(nzcv[3]), .alu_zero(nzcv[2]), .alu_carry(nzcv[1]), .alu_ovf(nzcv[0]),
        .br_valid(br_valid), .br_type(br_type), .br_reg(br_reg),
        .flags_q(flags_q), .br_resolved(br_resolved), .br_taken(br_taken), .taken_cnt(taken_cnt)
    );

    branch_cond_unit #(.WIDTH(64), .CNT_W(4)) dutSmall (
        .clk(clk), .reset(reset), .stall(1'b0), .flush(1'b0), .flag_we(1'b0),
        .alu_neg(1'b0), .alu_zero(1'b0), .alu_carry(1'b0), .alu_ovf(1'b0),
        .br_valid(smValid), .br_type(3'b000), .br_reg(64'h0),
        .flags_q(smFlags), .br_resolved(smResolved), .br_taken(smTaken), .taken_cnt(smCnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and post the expected post-edge state.
    task automatic vec(input logic st, input logic fl, input logic fwe, input logic [3:0] f,
                       input logic v, input logic [2:0] t, input logic [63:0] r,
                       input logic [3:0] eFlags, input logic eRes, input logic eTaken,
                       input logic [31:0] eCnt);
        exp_t e;
        @(negedge clk);
        stall = st; flush = fl; flag_we = fwe; nzcv = f;
        br_valid = v; br_type = t; br_reg = r;
        e.idx = vecIdx; e.flags = eFlags; e.res = eRes; e.taken = eTaken; e.cnt = eCnt;
        vecIdx++;
        expQ.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        stall = 1'b0; flush = 1'b0; flag_we = 1'b0; nzcv = 4'b0000;
        br_valid = 1'b0; br_type = 3'b111; br_reg = 64'hDEAD_BEEF;
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses never observed", expQ.size());
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                check($sformatf("v%0d flags_q", e.idx), 64'(flags_q), 64'(e.flags));
                check($sformatf("v%0d br_resolved", e.idx), 64'(br_resolved), 64'(e.res));
                check($sformatf("v%0d br_taken", e.idx), 64'(br_taken), 64'(e.taken));
                check($sformatf("v%0d taken_cnt", e.idx), 64'(taken_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : driver
        repeat (3) @(posedge clk);
        #1;
        check("reset flags_q", 64'(flags_q), 64'h0);
        check("reset br_resolved", 64'(br_resolved), 64'h0);
        check("reset br_taken", 64'(br_taken), 64'h0);
        check("reset taken_cnt", 64'(taken_cnt), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        //  st fl fwe nzcv   v  type    reg                    flags   res taken cnt
        vec(0, 0, 0, 4'b0000, 1, 3'b001, 64'h0,                  4'b0000, 1, 1, 1); // CBZ zero
        vec(0, 0, 0, 4'b0000, 1, 3'b001, 64'h8000_0000_0000_0000, 4'b0000, 1, 0, 1); // CBZ top bit
        vec(0, 0, 1, 4'b1000, 1, 3'b101, 64'h0,                  4'b1000, 1, 1, 2); // B.LT bypass
        vec(0, 0, 0, 4'b0000, 1, 3'b110, 64'h0,                  4'b1000, 1, 0, 2); // B.GE stored
        vec(0, 1, 1, 4'b0100, 1, 3'b011, 64'h0,                  4'b0100, 0, 0, 2); // flushed B.EQ
        vec(0, 0, 0, 4'b0000, 1, 3'b011, 64'h0,                  4'b0100, 1, 1, 3); // B.EQ stored Z
        vec(1, 0, 1, 4'b1111, 1, 3'b000, 64'h0,                  4'b0100, 1, 1, 3); // stall holds
        vec(1, 0, 1, 4'b1111, 1, 3'b000, 64'h0,                  4'b0100, 1, 1, 3);
        vec(1, 0, 1, 4'b1111, 1, 3'b000, 64'h0,                  4'b0100, 1, 1, 3);
        vec(0, 0, 0, 4'b0000, 1, 3'b000, 64'h0,                  4'b0100, 1, 1, 4); // released B
        vec(0, 0, 0, 4'b0000, 0, 3'b111, 64'hFFFF,               4'b0100, 0, 0, 4); // no branch
        vec(0, 0, 0, 4'b0000, 1, 3'b100, 64'h0,                  4'b0100, 1, 0, 4); // B.NE, Z=1
        vec(0, 0, 1, 4'b0010, 1, 3'b111, 64'h0,                  4'b0010, 1, 0, 4); // B.LO, C=1
        vec(0, 0, 1, 4'b0000, 1, 3'b111, 64'h0,                  4'b0000, 1, 1, 5); // B.LO, C=0
        vec(0, 0, 0, 4'b0000, 1, 3'b010, 64'h1,                  4'b0000, 1, 1, 6); // CBNZ nonzero
        vec(0, 0, 0, 4'b0000, 1, 3'b010, 64'h0,                  4'b0000, 1, 0, 6); // CBNZ zero
        vec(0, 0, 1, 4'b1001, 1, 3'b110, 64'h0,                  4'b1001, 1, 1, 7); // B.GE N==V
        vec(0, 0, 0, 4'b0000, 1, 3'b101, 64'h0,                  4'b1001, 1, 0, 7); // B.LT N==V
        vec(0, 0, 1, 4'b1111, 0, 3'b000, 64'h0,                  4'b1111, 0, 0, 7); // flags only
        vec(0, 0, 0, 4'b0000, 1, 3'b000, 64'h0,                  4'b1111, 1, 1, 8); // B taken
        idle();
        drain();

        // Async reset between edges while br_taken=1 and flags_q=1111.
        reset = 1'b1;
        #1;
        check("async flags_q", 64'(flags_q), 64'h0);
        check("async br_resolved", 64'(br_resolved), 64'h0);
        check("async br_taken", 64'(br_taken), 64'h0);
        check("async taken_cnt", 64'(taken_cnt), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        vec(0, 0, 0, 4'b0000, 1, 3'b000, 64'h0,                  4'b0000, 1, 1, 1); // first after reset
        idle();
        drain();

        // 4-bit counter saturates at 15 over 20 taken branches.
        @(negedge clk);
        smValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat taken_cnt step %0d", i), 64'(smCnt), 64'((i + 1 > 15) ? 15 : i + 1));
        end
        check("sat br_taken", 64'(smTaken), 64'h1);
        @(negedge clk);
        smValid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Consumer side of the ALU status path in the 5-stage pipelined CPU.
- Holds the architectural NZCV flag register, written by flag-setting instructions in EX.
- Resolves conditional branches (CBZ/CBNZ/B.cond) for the instruction in ID/EX, with a same-cycle flag bypass, and drives a registered taken/resolved pair to the fetch redirect logic.
- Keeps a saturating taken-branch counter for performance debug.

Parameters:
- WIDTH, 64, datapath width of the CBZ/CBNZ operand.
- CNT_W, 32, width of the taken-branch counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  pipeline stall; all internal state holds.
- flush  input  1  squash the branch currently presented; flag writes still commit.
- flag_we  input  1  EX instruction sets flags this cycle.
- alu_neg  input  1  ALU result bit 63.
- alu_zero  input  1  zero flag from the ALU zero detector (1 = result is 0).
- alu_carry  input  1  ALU carry out.
- alu_ovf  input  1  ALU signed overflow.
- br_valid  input  1  a branch is presented for resolution.
- br_type  input  3  000 B, 001 CBZ, 010 CBNZ, 011 B.EQ, 100 B.NE, 101 B.LT, 110 B.GE, 111 B.LO.
- br_reg  input  WIDTH  register operand for CBZ/CBNZ.
- flags_q  output  4  registered {N,Z,C,V}.
- br_resolved  output  1  registered; branch resolved last edge.
- br_taken  output  1  registered; resolved branch is taken.
- taken_cnt  output  CNT_W  saturating count of taken branches.

Behaviour:
- Reset values: while reset=1, and asynchronously on assertion, set flags_q=4'b0000, br_resolved=0, br_taken=0, taken_cnt=0. Reset overrides stall and flush.
- Flag register update:
  - At a rising edge with stall=0 and flag_we=1: flags_q <= {alu_neg, alu_zero, alu_carry, alu_ovf}.
  - Otherwise flags_q holds.
- Effective flags (combinational): eff = flag_we ? {alu_neg, alu_zero, alu_carry, alu_ovf} : flags_q. This bypasses a flag-setter that is in EX in the same cycle as a dependent B.cond.
- Operand zero detect (combinational): opz = 1 when br_reg == 0, computed over all WIDTH bits.
- Condition function, evaluated against eff and opz:
  - B: 1
  - CBZ: opz
  - CBNZ: !opz
  - B.EQ: Z
  - B.NE: !Z
  - B.LT: N != V
  - B.GE: N == V
  - B.LO: !C
- Resolution, at a rising edge with stall=0:
  - br_resolved <= br_valid & !flush.
  - br_taken <= br_valid & !flush & cond.
  - Latency is one cycle: the outputs are valid the cycle after br_valid is sampled.
- Stall: when stall=1, br_resolved, br_taken, flags_q and taken_cnt all hold their values. br_valid presented during a stall is not consumed; upstream holds it until stall drops.
- Flush: when flush=1 and stall=0, the presented branch is squashed (br_resolved=0, br_taken=0 next cycle). A simultaneous flag_we still updates flags_q.
- Counter:
  - At a rising edge with stall=0, when the branch resolves taken (br_valid & !flush & cond), taken_cnt increments by 1.
  - taken_cnt saturates at 2^CNT_W−1 and does not wrap.
- Simultaneous flag_we and B.cond: the branch uses the new ALU flags (bypass), and flags_q also updates at the same edge.
- Reset mid-operation: any pending resolution is lost and outputs return to their reset values immediately. After reset deasserts, the first edge with stall=0 behaves normally.
- No X propagation: br_type and br_reg are ignored when br_valid=0.

Test Plan:
- Reset, then CBZ with br_reg=64'h0, br_valid=1 -> next cycle br_resolved=1, br_taken=1, taken_cnt=1. Repeat with br_reg=64'h8000_0000_0000_0000 -> br_taken=0, taken_cnt stays 1.
- flag_we=1 with N=1,Z=0,C=0,V=0 in the same cycle as B.LT -> br_taken=1 (bypass), flags_q=4'b1000 next cycle. Following cycle, B.GE with flag_we=0 -> br_taken=0.
- B.EQ presented with flush=1 and flag_we=1, Z=1 -> br_resolved=0, br_taken=0, taken_cnt unchanged, flags_q=4'b0100.
- stall=1 for 3 cycles with br_valid=1, B (unconditional) -> outputs and taken_cnt hold. On the first cycle with stall=0 -> br_taken=1, counter +1 exactly once.
- CNT_W=4, issue 20 taken B branches -> taken_cnt stops at 15.
- Assert reset asynchronously between edges while br_taken=1 and flags_q=4'b1111 -> all outputs read 0 before the next clock edge.
